// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch controller: owns the fetch PC, reads imem, and queues up to
// two {pc, inst} entries for decode behind a valid/ready handshake.
module imem_fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 2048
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en,
  output logic [31:0] im_addr,
  output logic        im_r,
  input  logic [31:0] im_rd,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        fault
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam logic [29:0] WORD_LIMIT = 30'(IMEM_WORDS);

  state_t      state_q, state_d;
  logic        fault_q, fault_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] pc0_q, pc0_d, inst0_q, inst0_d;
  logic [31:0] pc1_q, pc1_d, inst1_q, inst1_d;

  logic pop, space, addr_ok, try_fetch, issue, fault_set;

  always_comb begin
    pop       = if_valid & if_ready;
    space     = (state_q != FULL) | pop;
    addr_ok   = (fetch_pc_q[1:0] == 2'b00) & (fetch_pc_q[31:2] < WORD_LIMIT);
    try_fetch = fetch_en & space & ~fault_q & ~redirect;
    issue     = try_fetch & addr_ok;
    fault_set = try_fetch & ~addr_ok;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  // Next-state logic: occupancy tracks push/pop, redirect empties the queue
  always_comb begin
    state_d = state_q;
    if (redirect) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY:   if (issue) state_d = HALF;
        HALF: begin
          if (issue & ~pop)      state_d = FULL;
          else if (pop & ~issue) state_d = EMPTY;
        end
        FULL:    if (pop & ~issue) state_d = HALF;
        default: state_d = EMPTY;
      endcase
    end
  end

  // Output logic
  always_comb begin
    if_valid = (state_q != EMPTY);
    if_pc    = pc0_q;
    if_inst  = inst0_q;
    fault    = fault_q;
    im_addr  = fetch_pc_q;
    im_r     = issue & ~rst;
  end

  // Datapath: entry 0 is the head; a pop shifts entry 1 forward
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    fault_d    = fault_q | fault_set;
    pc0_d      = pc0_q;
    inst0_d    = inst0_q;
    pc1_d      = pc1_q;
    inst1_d    = inst1_q;
    if (redirect) begin
      fetch_pc_d = redirect_pc;
      fault_d    = 1'b0;
    end else begin
      if (pop) begin
        pc0_d   = pc1_q;
        inst0_d = inst1_q;
      end
      if (issue) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
        // The new entry lands in the first slot left free after this cycle's pop
        if ((state_q == EMPTY) || ((state_q == HALF) && pop)) begin
          pc0_d   = fetch_pc_q;
          inst0_d = im_rd;
        end else begin
          pc1_d   = fetch_pc_q;
          inst1_d = im_rd;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      fault_q    <= 1'b0;
      pc0_q      <= '0;
      inst0_q    <= '0;
      pc1_q      <= '0;
      inst1_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      fault_q    <= fault_d;
      pc0_q      <= pc0_d;
      inst0_q    <= inst0_d;
      pc1_q      <= pc1_d;
      inst1_q    <= inst1_d;
    end
  end

endmodule

// File: doc/imem_fetch_ctrl.md
# imem_fetch_ctrl

Instruction-fetch controller that sequences reads of the word-addressed instruction memory (`imem`, 2048 × 32-bit, combinational read gated by `IM_R`) and delivers instructions to decode through a valid/ready handshake. It owns the fetch PC, buffers up to two fetched instructions in a small queue, and absorbs decode stalls, control-flow redirects and out-of-range fetches. It sits between the PC/branch logic and the decode stage of the CPU.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000: fetch address after reset.
- `IMEM_WORDS`, 2048: number of instruction words; a fetch at or beyond this is a fault.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset; one clock, asynchronous and active-high.
- `fetch_en` in 1: fetch permitted; 0 halts new fetches without affecting queued entries.
- `im_addr` out 32: byte address to imem (`a`); equals `fetch_pc` at all times.
- `im_r` out 1: imem read enable (`IM_R`); combinational.
- `im_rd` in 32: imem read data (`rd`), valid in the same cycle as `im_r`.
- `if_valid` out 1: queue head holds an instruction.
- `if_ready` in 1: decode accepts the head this cycle.
- `if_inst` out 32: head instruction.
- `if_pc` out 32: byte address of the head instruction.
- `redirect` in 1: branch/jump/exception; flush and refetch.
- `redirect_pc` in 32: new fetch address, sampled when `redirect` = 1.
- `fault` out 1: sticky fetch-address fault.

## Operation
- State: `fetch_pc` (32 bit); a 2-entry FIFO of {pc, inst}; `count` (0..2); `fault` flag.
- Pop: `if_valid & if_ready`. This is a completed transfer, including in a redirect cycle.
- `space` = (`count` < 2) | pop.
- `issue` = `fetch_en & space & ~fault & ~redirect & addr_ok`.
  - `addr_ok` = (`fetch_pc[1:0]` == 0) & (`fetch_pc[31:2]` < `IMEM_WORDS`).
- `im_r` = `issue`. When `im_r` = 0, `im_rd` is ignored; imem returns X.
- On issue: push {`fetch_pc`, `im_rd`} and set `fetch_pc` <= `fetch_pc` + 4, wrapping modulo 2^32.
- Fault: if `fetch_en & space & ~fault & ~redirect & ~addr_ok`, set `fault` <= 1.
  - No push; `fetch_pc` holds.
  - Queued entries stay deliverable.
  - The fault is cleared only by `redirect` or `rst`.
- Redirect, highest priority:
  - Next state: `count` <= 0 and `fetch_pc` <= `redirect_pc`.
  - `fault` <= 0.
  - No issue in the redirect cycle.
  - A pop in the same cycle is delivered; all other entries are discarded.
  - A bad `redirect_pc` faults on the following cycle through the normal `addr_ok` check.
- Push and pop in the same cycle are allowed at any `count`, including 2: the count is unchanged and the order is preserved.
- `if_inst` and `if_pc` hold stable while `if_valid & ~if_ready`.
- FSM, derived from `count` and `fault`:
  - EMPTY → HALF on push.
  - HALF → FULL on push without pop.
  - FULL → HALF on pop without push.
  - HALF → EMPTY on pop without push.
  - Any state → EMPTY on redirect.
  - FAULT is orthogonal: it stops issue and does not block draining.

## Timing
- Reset values:
  - `fetch_pc` = `RESET_PC`, `count` = 0, `fault` = 0.
  - `if_valid` = 0, `if_inst` = 0, `if_pc` = 0; all queue entries = 0.
  - `im_r` = 0 while `rst` = 1; `im_addr` = `RESET_PC`.
- Reset asserted mid-operation clears everything immediately, asynchronously; the in-flight fetch is lost.
- Fetch-to-valid latency is 1 cycle: an issue in cycle N gives `if_valid` = 1 in cycle N+1.
- Redirect-to-valid latency:
  - Cycle N: `redirect` = 1.
  - Cycle N+1: issue at `redirect_pc`.
  - Cycle N+2: `if_valid` = 1 with `if_pc` = `redirect_pc`.
- Throughput is 1 instruction/cycle with `if_ready` held high.
- `fault` rises 1 cycle after the failing address is presented with `fetch_en & space`.
- `im_r` and `im_addr` are the only combinational outputs. `if_*` and `fault` are registered.

## Test plan
- Reset with `RESET_PC` = 0, imem word i = 32'h1000_0000 + i, `if_ready` = 1 → `if_valid` rises 1 cycle after reset release; pairs {if_pc, if_inst} = {0, 1000_0000}, {4, 1000_0001}, {8, 1000_0002} on consecutive cycles.
- Backpressure: `if_ready` = 0 for 5 cycles → exactly 2 issues (`im_r` pulses twice), then `im_r` = 0 with `if_pc` = 0 held stable; on release, 0, 4, 8 are delivered with no gap and no duplicate.
- Redirect to 32'h40 while `count` = 2 and `if_ready` = 1 → head pc 0 delivered; pc 4 discarded; next delivered `if_pc` = 32'h40 two cycles later with `if_inst` = 1000_0010.
- Range fault: redirect to 32'h1FFC (word 2047), then continue → 1FFC delivered; fetch at 32'h2000 sets `fault` = 1; `im_r` stays 0; a later redirect to 0 clears `fault` and refetches 0.
- Misaligned redirect to 32'h6 → `fault` = 1 next cycle, no `im_r` pulse, `if_valid` = 0.
- Simultaneous push+pop at `count` = 2 with `fetch_en` toggling 1/0 per cycle → order strictly sequential, `count` never exceeds 2; `rst` pulse mid-stream → `if_valid` = 0 immediately and fetch restarts at `RESET_PC`.
